// File: rtl/net_bus_tx_arb.sv
// Four-source packet arbiter onto one NetBus transmit link.
// The arbiter grants sources in round-robin order. A granted source keeps the
// link until its LAST beat is accepted. The output beat is registered, so the
// link still runs at full valid/ready throughput.
//
// state | meaning
// IDLE  | no packet owns the link; choose the next requester after PTR
// LOCK  | requester GRANT owns the link until its LAST beat transfers
module net_bus_tx_arb #(
  parameter int DATA_WIDTH = 4,
  localparam int W = DATA_WIDTH * 9 + 14
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] DATA0,
  input  logic [W-1:0] DATA1,
  input  logic [W-1:0] DATA2,
  input  logic [W-1:0] DATA3,
  input  logic         VALID0,
  input  logic         VALID1,
  input  logic         VALID2,
  input  logic         VALID3,
  input  logic         LAST0,
  input  logic         LAST1,
  input  logic         LAST2,
  input  logic         LAST3,
  output logic         READY0,
  output logic         READY1,
  output logic         READY2,
  output logic         READY3,
  output logic         WCLK,
  output logic [W-1:0] WDATA,
  output logic         WVALID,
  output logic         WLAST,
  input  logic         WREADY,
  output logic [1:0]   GRANT,
  output logic         BUSY
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t       state, state_nxt;
  logic [1:0]   grant_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic [1:0]   cand;
  logic [W-1:0] data_arr [4];
  logic [3:0]   valid_v;
  logic [3:0]   last_v;
  logic [3:0]   ready_v;
  logic [W-1:0] sel_data;
  logic         sel_valid;
  logic         sel_last;
  logic         en;
  logic         xfer;

  assign WCLK = CLK;

  assign data_arr[0] = DATA0;
  assign data_arr[1] = DATA1;
  assign data_arr[2] = DATA2;
  assign data_arr[3] = DATA3;
  assign valid_v     = {VALID3, VALID2, VALID1, VALID0};
  assign last_v      = {LAST3, LAST2, LAST1, LAST0};

  // The output register can take a new beat when it is empty or is draining.
  assign en        = !WVALID || WREADY;
  assign BUSY      = (state == LOCK);
  assign sel_data  = data_arr[GRANT];
  assign sel_valid = valid_v[GRANT];
  assign sel_last  = last_v[GRANT];
  assign xfer      = BUSY && en && sel_valid;

  // Only the locked owner can see READY, and only while the register can accept.
  always_comb begin
    ready_v = 4'b0000;
    if (BUSY && en) ready_v[GRANT] = 1'b1;
  end

  assign READY0 = ready_v[0];
  assign READY1 = ready_v[1];
  assign READY2 = ready_v[2];
  assign READY3 = ready_v[3];

  // Register the arbitration state: FSM state, grant, and round-robin pointer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      GRANT <= 2'd0;
      ptr   <= 2'd3;
    end else begin
      state <= state_nxt;
      GRANT <= grant_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state: round-robin pick in IDLE, and release on the accepted LAST beat in LOCK.
  always_comb begin
    state_nxt = state;
    grant_nxt = GRANT;
    ptr_nxt   = ptr;
    cand      = 2'd0;
    case (state)
      IDLE: begin
        if (|valid_v) begin
          state_nxt = LOCK;
          // Scan from the farthest offset to the nearest. The nearest valid
          // requester after ptr is assigned last, so it wins.
          for (int i = 4; i >= 1; i--) begin
            cand = ptr + i[1:0];
            if (valid_v[cand]) grant_nxt = cand;
          end
        end
      end
      LOCK: begin
        if (xfer && sel_last) begin
          state_nxt = IDLE;
          ptr_nxt   = GRANT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output beat register: load on a transfer, go empty when drained and nothing arrives.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WDATA  <= '0;
      WVALID <= 1'b0;
      WLAST  <= 1'b0;
    end else if (xfer) begin
      WDATA  <= sel_data;
      WLAST  <= sel_last;
      WVALID <= 1'b1;
    end else if (en) begin
      WVALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_net_bus_tx_arb.sv
// Directed bench for net_bus_tx_arb, followed by a randomized packet-integrity run.
module tb_net_bus_tx_arb;
  localparam int DW = 4;
  localparam int W  = DW * 9 + 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data [4];
  logic [3:0]   valid;
  logic [3:0]   last;
  logic [3:0]   ready;
  logic         wclk;
  logic [W-1:0] wdata;
  logic         wvalid;
  logic         wlast;
  logic         wready;
  logic [1:0]   grant;
  logic         busy;

  int checks = 0;
  int errors = 0;

  int src_pkt [4];
  int src_beat [4];
  int src_len [4];
  int exp_pkt [4];
  int exp_beat [4];
  int sent = 0;
  int rcvd = 0;
  logic       mon_active;
  logic [1:0] mon_owner;

  net_bus_tx_arb #(.DATA_WIDTH(DW)) dut (
    .CLK(clk), .RST(rst),
    .DATA0(data[0]), .DATA1(data[1]), .DATA2(data[2]), .DATA3(data[3]),
    .VALID0(valid[0]), .VALID1(valid[1]), .VALID2(valid[2]), .VALID3(valid[3]),
    .LAST0(last[0]), .LAST1(last[1]), .LAST2(last[2]), .LAST3(last[3]),
    .READY0(ready[0]), .READY1(ready[1]), .READY2(ready[2]), .READY3(ready[3]),
    .WCLK(wclk), .WDATA(wdata), .WVALID(wvalid), .WLAST(wlast), .WREADY(wready),
    .GRANT(grant), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    valid = 4'b0000;
    last  = 4'b0000;
    for (int i = 0; i < 4; i++) data[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    wready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One randomized cycle: drive sources at negedge, then account for the transfers
  // that the next posedge will perform.
  task automatic rand_cycle(input bit src_on);
    logic [1:0] id;
    int         pk, bt;
    logic       lb;
    @(negedge clk);
    wready = src_on ? ($urandom_range(0, 3) != 0) : 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid[i] = src_on && ($urandom_range(0, 3) != 0);
      last[i]  = (src_beat[i] == src_len[i] - 1);
      data[i]  = {{(W-27){1'b0}}, i[1:0], src_pkt[i][15:0], src_beat[i][7:0], last[i]};
    end
    #1;
    chk("ready_onehot", $countones(ready) <= 1, 1);
    for (int i = 0; i < 4; i++) begin
      if (ready[i] && valid[i]) begin
        sent++;
        if (last[i]) begin
          src_pkt[i]++;
          src_beat[i] = 0;
          src_len[i]  = $urandom_range(1, 5);
        end else begin
          src_beat[i]++;
        end
      end
    end
    if (wvalid && wready) begin
      id = wdata[26:25];
      pk = int'(wdata[24:9]);
      bt = int'(wdata[8:1]);
      lb = wdata[0];
      rcvd++;
      if (mon_active) chk("contiguous_owner", id, mon_owner);
      chk("pkt_seq", pk, exp_pkt[id]);
      chk("beat_seq", bt, exp_beat[id]);
      chk("wlast_match", wlast, lb);
      if (lb) begin
        exp_pkt[id]++;
        exp_beat[id] = 0;
        mon_active   = 1'b0;
      end else begin
        exp_beat[id]++;
        mon_active = 1'b1;
        mon_owner  = id;
      end
    end
  endtask

  initial begin
    clear_inputs();
    wready = 1'b1;
    rst    = 1'b1;
    tick();
    tick();
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_ready", ready, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    rst = 1'b0;

    // Test 1: a 3-beat packet from requester 0.
    valid[0] = 1'b1; data[0] = 'h11; last[0] = 1'b0;
    #1 chk("t1_idle_no_ready", ready[0], 0);
    tick();
    chk("t1_grant", grant, 0);
    chk("t1_busy", busy, 1);
    chk("t1_ready_c1", ready[0], 1);
    tick();
    chk("t1_wdata_c2", wdata, 'h11);
    chk("t1_wvalid_c2", wvalid, 1);
    chk("t1_wlast_c2", wlast, 0);
    chk("t1_ready_c2", ready[0], 1);
    data[0] = 'h22;
    tick();
    chk("t1_wdata_c3", wdata, 'h22);
    chk("t1_ready_c3", ready[0], 1);
    data[0] = 'h33; last[0] = 1'b1;
    tick();
    chk("t1_wdata_c4", wdata, 'h33);
    chk("t1_wlast_c4", wlast, 1);
    chk("t1_busy_c4", busy, 0);
    chk("t1_ready_c4", ready[0], 0);
    valid[0] = 1'b0; last[0] = 1'b0;
    tick();
    chk("t1_wvalid_c5", wvalid, 0);

    // Test 2: all four requesters send 1-beat packets; grants go 0,1,2,3,0.
    do_reset();
    valid = 4'b1111; last = 4'b1111;
    for (int n = 0; n < 4; n++) data[n] = W'('hA0 + n);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_grant", grant, k % 4);
      chk("t2_busy", busy, 1);
      chk("t2_ready", ready, 4'b0001 << (k % 4));
      tick();
      chk("t2_bubble_busy", busy, 0);
      chk("t2_bubble_ready", ready, 4'b0000);
      chk("t2_wdata", wdata, 'hA0 + (k % 4));
      chk("t2_wlast", wlast, 1);
    end
    valid = 4'b0000; last = 4'b0000;
    tick();
    chk("t2_drained", wvalid, 0);

    // Test 3: link backpressure while requester 2 is locked.
    valid[2] = 1'b1; data[2] = 'h51; last[2] = 1'b0;
    tick();
    chk("t3_grant", grant, 2);
    chk("t3_ready_c1", ready[2], 1);
    tick();
    chk("t3_wdata_first", wdata, 'h51);
    data[2] = 'h52;
    wready = 1'b0;
    #1 chk("t3_ready_full", ready[2], 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t3_hold_wdata", wdata, 'h51);
      chk("t3_hold_wvalid", wvalid, 1);
      chk("t3_hold_wlast", wlast, 0);
      chk("t3_hold_ready", ready[2], 0);
    end
    wready = 1'b1;
    #1 chk("t3_ready_resume", ready[2], 1);
    chk("t3_wdata_still", wdata, 'h51);
    tick();
    chk("t3_wdata_52", wdata, 'h52);
    data[2] = 'h53;
    tick();
    chk("t3_wdata_53", wdata, 'h53);
    data[2] = 'h54; last[2] = 1'b1;
    tick();
    chk("t3_wdata_54", wdata, 'h54);
    chk("t3_wlast_54", wlast, 1);
    chk("t3_busy_end", busy, 0);
    valid[2] = 1'b0; last[2] = 1'b0;
    tick();

    // Test 4: requester 1 stalls mid-packet while requester 3 waits.
    valid[1] = 1'b1; data[1] = 'h61; last[1] = 1'b0;
    tick();
    chk("t4_grant1", grant, 1);
    valid[3] = 1'b1; data[3] = 'h71; last[3] = 1'b1;
    #1 chk("t4_ready1", ready[1], 1);
    chk("t4_ready3_c1", ready[3], 0);
    tick();
    chk("t4_wdata_61", wdata, 'h61);
    valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_hold_grant", grant, 1);
      chk("t4_hold_busy", busy, 1);
      chk("t4_starve3", ready[3], 0);
      tick();
    end
    valid[1] = 1'b1; data[1] = 'h62; last[1] = 1'b1;
    #1 chk("t4_ready1_resume", ready[1], 1);
    tick();
    chk("t4_wdata_62", wdata, 'h62);
    chk("t4_wlast_62", wlast, 1);
    chk("t4_busy_end", busy, 0);
    chk("t4_grant_held", grant, 1);
    valid[1] = 1'b0; last[1] = 1'b0;
    tick();
    chk("t4_grant3", grant, 3);
    chk("t4_ready3", ready[3], 1);
    tick();
    chk("t4_wdata_71", wdata, 'h71);
    valid[3] = 1'b0; last[3] = 1'b0;
    tick();

    // Test 5: asynchronous reset with a beat held in the output register.
    valid[2] = 1'b1; data[2] = 'h91; last[2] = 1'b0;
    tick();
    chk("t5_grant2", grant, 2);
    wready = 1'b0;
    tick();
    chk("t5_wvalid_full", wvalid, 1);
    chk("t5_wdata_91", wdata, 'h91);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_wvalid", wvalid, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_ready", ready, 4'b0000);
    chk("t5_async_grant", grant, 0);
    tick();
    rst = 1'b0;
    wready = 1'b1;
    valid[0] = 1'b1; data[0] = 'h80; last[0] = 1'b1;
    data[2] = 'h82; last[2] = 1'b1;
    tick();
    chk("t5_grant0_first", grant, 0);
    chk("t5_ready0", ready[0], 1);
    tick();
    chk("t5_wdata_80", wdata, 'h80);
    clear_inputs();

    // Test 6: random traffic, with packets checked for sequence and contiguity.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_pkt[i]  = 0;
      src_beat[i] = 0;
      src_len[i]  = $urandom_range(1, 5);
      exp_pkt[i]  = 0;
      exp_beat[i] = 0;
    end
    mon_active = 1'b0;
    mon_owner  = 2'd0;
    for (int c = 0; c < 3000; c++) rand_cycle(1'b1);
    for (int c = 0; c < 8; c++) rand_cycle(1'b0);
    chk("rand_traffic_nonzero", sent > 100, 1);
    chk("rand_beats_conserved", rcvd, sent);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
